// File: rtl/match_ctrl.sv
// match_ctrl: N-player round/match controller for the tank game.
// Tracks lives, respawn timers and round wins per player, and drives
// freeze/respawn to the tank and bullet units plus a status word per player.
//
// state      | meaning
// -----------+--------------------------------------------------------
// IDLE       | after reset, frozen, waiting for start
// COUNTDOWN  | frozen pre-round countdown, lives reloaded
// PLAY       | tanks move, hits and respawns processed
// ROUND_HOLD | frozen post-round display of the round result
// MATCH_OVER | a player reached the win target, waiting for start
module match_ctrl #(
  parameter int NUM_PLAYERS       = 2,
  parameter int LIVES             = 3,
  parameter int WINS_TO_MATCH     = 3,
  parameter int RESPAWN_FRAMES    = 60,
  parameter int COUNTDOWN_FRAMES  = 120,
  parameter int ROUND_HOLD_FRAMES = 180,
  parameter int PID_W             = $clog2(NUM_PLAYERS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     frame_tick,
  input  logic                     start,
  input  logic [NUM_PLAYERS-1:0]   hit,
  output logic                     freeze,
  output logic [NUM_PLAYERS-1:0]   respawn,
  output logic [NUM_PLAYERS-1:0]   alive,
  output logic [NUM_PLAYERS-1:0]   eliminated,
  output logic                     round_over,
  output logic                     match_over,
  output logic [PID_W-1:0]         winner,
  output logic                     winner_valid,
  output logic [32*NUM_PLAYERS-1:0] status_data
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_COUNTDOWN  = 3'd1,
    S_PLAY       = 3'd2,
    S_ROUND_HOLD = 3'd3,
    S_MATCH_OVER = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [3:0]             lives_q [NUM_PLAYERS];
  logic [3:0]             lives_d [NUM_PLAYERS];
  logic [3:0]             wins_q  [NUM_PLAYERS];
  logic [3:0]             wins_d  [NUM_PLAYERS];
  logic [5:0]             tmr_q   [NUM_PLAYERS];
  logic [5:0]             tmr_d   [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] alive_q, alive_d;
  logic [NUM_PLAYERS-1:0] elim_q, elim_d;
  logic [NUM_PLAYERS-1:0] respawn_q, respawn_d;
  logic [PID_W-1:0]       winner_q, winner_d;
  logic                   winner_valid_q, winner_valid_d;
  logic                   freeze_q, round_over_q, match_over_q;
  logic                   enter_cd;
  logic [3:0]             surv_cnt;
  logic [PID_W-1:0]       surv_idx;
  logic                   wins_done;

  // Survivor count from the registered eliminated vector, plus win-target check.
  always_comb begin
    surv_cnt  = 4'd0;
    surv_idx  = '0;
    wins_done = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (!elim_q[i]) begin
        surv_cnt = surv_cnt + 4'd1;
        surv_idx = PID_W'(i);
      end
      if (wins_q[i] == 4'(WINS_TO_MATCH)) wins_done = 1'b1;
    end
  end

  // Next-state and per-player bookkeeping.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    lives_d        = lives_q;
    wins_d         = wins_q;
    tmr_d          = tmr_q;
    alive_d        = alive_q;
    elim_d         = elim_q;
    respawn_d      = '0;
    winner_d       = winner_q;
    winner_valid_d = winner_valid_q;
    enter_cd       = 1'b0;

    case (state_q)
      S_IDLE, S_MATCH_OVER: begin
        if (start) begin
          for (int i = 0; i < NUM_PLAYERS; i++) wins_d[i] = 4'd0;
          enter_cd = 1'b1;
        end
      end
      S_COUNTDOWN: begin
        if (frame_tick) begin
          if (cnt_q <= 8'd1) begin
            cnt_d     = 8'd0;
            state_d   = S_PLAY;
            respawn_d = '1;
            alive_d   = '1;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      S_PLAY: begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          if (frame_tick && tmr_q[i] != 6'd0) begin
            tmr_d[i] = tmr_q[i] - 6'd1;
            if (tmr_q[i] == 6'd1) begin
              alive_d[i]   = 1'b1;
              respawn_d[i] = 1'b1;
            end
          end
          if (hit[i] && alive_q[i] && lives_q[i] != 4'd0) begin
            lives_d[i] = lives_q[i] - 4'd1;
            alive_d[i] = 1'b0;
            if (lives_q[i] == 4'd1) elim_d[i] = 1'b1;
            else                    tmr_d[i]  = 6'(RESPAWN_FRAMES);
          end
        end
        if (surv_cnt <= 4'd1) begin
          state_d = S_ROUND_HOLD;
          cnt_d   = 8'(ROUND_HOLD_FRAMES);
          for (int i = 0; i < NUM_PLAYERS; i++) tmr_d[i] = 6'd0;
          if (surv_cnt == 4'd1) begin
            wins_d[surv_idx] = wins_q[surv_idx] + 4'd1;
            winner_d         = surv_idx;
            winner_valid_d   = 1'b1;
          end else begin
            winner_valid_d = 1'b0;
          end
        end
      end
      S_ROUND_HOLD: begin
        if (frame_tick) begin
          if (cnt_q <= 8'd1) begin
            cnt_d = 8'd0;
            if (wins_done) state_d  = S_MATCH_OVER;
            else           enter_cd = 1'b1;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every path into COUNTDOWN gets the same fresh round setup.
    if (enter_cd) begin
      state_d = S_COUNTDOWN;
      cnt_d   = 8'(COUNTDOWN_FRAMES);
      alive_d = '0;
      elim_d  = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        lives_d[i] = 4'(LIVES);
        tmr_d[i]   = 6'd0;
      end
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= 8'd0;
      alive_q        <= '0;
      elim_q         <= '0;
      respawn_q      <= '0;
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
      freeze_q       <= 1'b1;
      round_over_q   <= 1'b0;
      match_over_q   <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        lives_q[i] <= 4'd0;
        wins_q[i]  <= 4'd0;
        tmr_q[i]   <= 6'd0;
      end
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      alive_q        <= alive_d;
      elim_q         <= elim_d;
      respawn_q      <= respawn_d;
      winner_q       <= winner_d;
      winner_valid_q <= winner_valid_d;
      freeze_q       <= (state_d != S_PLAY);
      round_over_q   <= (state_d == S_ROUND_HOLD);
      match_over_q   <= (state_d == S_MATCH_OVER);
      lives_q        <= lives_d;
      wins_q         <= wins_d;
      tmr_q          <= tmr_d;
    end
  end

  // Pack per-player status words for the renderer.
  always_comb begin
    status_data = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      status_data[32*i +: 32] = {wins_q[i], lives_q[i], alive_q[i], elim_q[i],
                                 tmr_q[i], 13'd0, state_q};
    end
  end

  assign freeze       = freeze_q;
  assign respawn      = respawn_q;
  assign alive        = alive_q;
  assign eliminated   = elim_q;
  assign round_over   = round_over_q;
  assign match_over   = match_over_q;
  assign winner       = winner_q;
  assign winner_valid = winner_valid_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Directed self-checking bench for match_ctrl: a default two-player instance
// and a short-timer eight-player instance.
module tb_match_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  hit = '0;
  logic        freeze, round_over, match_over, winner_valid;
  logic [1:0]  respawn, alive, eliminated;
  logic [0:0]  winner;
  logic [63:0] status_data;

  logic        tick8 = 1'b0;
  logic        start8 = 1'b0;
  logic [7:0]  hit8 = '0;
  logic        freeze8, round_over8, match_over8, winner_valid8;
  logic [7:0]  respawn8, alive8, elim8;
  logic [2:0]  winner8;
  logic [255:0] status8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  match_ctrl dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .start(start), .hit(hit),
    .freeze(freeze), .respawn(respawn), .alive(alive), .eliminated(eliminated),
    .round_over(round_over), .match_over(match_over), .winner(winner),
    .winner_valid(winner_valid), .status_data(status_data)
  );

  match_ctrl #(
    .NUM_PLAYERS(8), .LIVES(1), .WINS_TO_MATCH(3), .RESPAWN_FRAMES(4),
    .COUNTDOWN_FRAMES(2), .ROUND_HOLD_FRAMES(2)
  ) dut8 (
    .clk(clk), .reset_n(reset_n), .frame_tick(tick8), .start(start8), .hit(hit8),
    .freeze(freeze8), .respawn(respawn8), .alive(alive8), .eliminated(elim8),
    .round_over(round_over8), .match_over(match_over8), .winner(winner8),
    .winner_valid(winner_valid8), .status_data(status8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    frame_tick = 1'b1;
    repeat (n) step();
    frame_tick = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] wins_of(input int p);
    return status_data[32*p+28 +: 4];
  endfunction

  function automatic logic [3:0] lives_of(input int p);
    return status_data[32*p+24 +: 4];
  endfunction

  function automatic logic [2:0] state_of();
    return status_data[2:0];
  endfunction

  initial begin
    // 1. reset and start
    step(); step();
    reset_n = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    chk("cd_state", 32'(state_of()), 1);
    chk("cd_lives", 32'(lives_of(1)), 3);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_status", status_data[31:0] | status_data[63:32], 0);
    chk("rst_freeze", 32'(freeze), 1);
    chk("rst_outs", {26'd0, respawn, alive, eliminated}, 0);
    chk("rst_flags", {29'd0, round_over, match_over, winner_valid}, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    ticks(119);
    chk("cd_last_tick", 32'(state_of()), 1);
    chk("cd_freeze", 32'(freeze), 1);
    ticks(1);
    chk("play_state", 32'(state_of()), 2);
    chk("play_respawn", 32'(respawn), 2'b11);
    chk("play_alive", 32'(alive), 2'b11);
    chk("play_freeze", 32'(freeze), 0);
    step();
    chk("respawn_width", 32'(respawn), 0);

    // 2. single hit and respawn
    hit = 2'b01; step(); hit = 2'b00;
    chk("hit_lives0", 32'(lives_of(0)), 2);
    chk("hit_alive", 32'(alive), 2'b10);
    chk("hit_timer", 32'(status_data[21:16]), 60);
    hit = 2'b01; step(); hit = 2'b00;
    chk("dead_hit_lives0", 32'(lives_of(0)), 2);
    ticks(59);
    chk("timer_one", 32'(status_data[21:16]), 1);
    chk("still_dead", 32'(alive), 2'b10);
    ticks(1);
    chk("respawn0", 32'(respawn), 2'b01);
    chk("alive_again", 32'(alive), 2'b11);
    step();
    chk("respawn0_clear", 32'(respawn), 0);

    // 3. round win by player 0
    for (int k = 0; k < 2; k++) begin
      hit = 2'b10; step(); hit = 2'b00;
      ticks(60);
    end
    hit = 2'b10; step(); hit = 2'b00;
    chk("elim1", 32'(eliminated), 2'b10);
    chk("still_play", 32'(round_over), 0);
    step();
    chk("round_over", 32'(round_over), 1);
    chk("win_state", 32'(state_of()), 3);
    chk("win_freeze", 32'(freeze), 1);
    chk("winner0", 32'(winner), 0);
    chk("winner_valid", 32'(winner_valid), 1);
    chk("wins0", 32'(wins_of(0)), 1);
    ticks(179);
    chk("hold_last_tick", 32'(state_of()), 3);
    ticks(1);
    chk("back_cd", 32'(state_of()), 1);
    chk("lives1_reload", 32'(lives_of(1)), 3);
    chk("elim_clear", 32'(eliminated), 0);

    // 4. draw
    ticks(120);
    for (int k = 0; k < 2; k++) begin
      hit = 2'b11; step(); hit = 2'b00;
      ticks(60);
    end
    chk("draw_lives", {lives_of(0), lives_of(1)}, 8'h11);
    hit = 2'b11; step(); hit = 2'b00;
    chk("draw_elim", 32'(eliminated), 2'b11);
    step();
    chk("draw_state", 32'(state_of()), 3);
    chk("draw_valid", 32'(winner_valid), 0);
    chk("draw_wins", {wins_of(0), wins_of(1)}, 8'h10);
    ticks(180);
    chk("draw_to_cd", 32'(state_of()), 1);

    // 5. player 1 wins three rounds
    for (int r = 0; r < 3; r++) begin
      ticks(120);
      if (r == 0) begin
        start = 1'b1; step(); start = 1'b0;
        chk("start_in_play", 32'(state_of()), 2);
        chk("start_in_play_lives", 32'(lives_of(0)), 3);
      end
      for (int k = 0; k < 2; k++) begin
        hit = 2'b01; step(); hit = 2'b00;
        ticks(60);
      end
      hit = 2'b01; step(); hit = 2'b00;
      step();
      chk("p1_round_winner", 32'(winner), 1);
      chk("p1_round_wins", 32'(wins_of(1)), 32'(r + 1));
      ticks(180);
    end
    chk("mo_state", 32'(state_of()), 4);
    chk("mo_flag", 32'(match_over), 1);
    chk("mo_winner", 32'(winner), 1);
    chk("mo_valid", 32'(winner_valid), 1);
    chk("mo_freeze", 32'(freeze), 1);
    ticks(3);
    chk("mo_hold", 32'(state_of()), 4);
    start = 1'b1; step(); start = 1'b0;
    chk("restart_state", 32'(state_of()), 1);
    chk("restart_wins", {wins_of(0), wins_of(1)}, 0);
    chk("restart_mo", 32'(match_over), 0);

    // 6. eight players
    start8 = 1'b1; step(); start8 = 1'b0;
    tick8 = 1'b1; step(); step(); tick8 = 1'b0;
    chk("p8_alive", 32'(alive8), 8'hff);
    hit8 = 8'h7f; step(); hit8 = 8'h00;
    chk("p8_elim", 32'(elim8), 8'h7f);
    step();
    chk("p8_round_over", 32'(round_over8), 1);
    chk("p8_winner", 32'(winner8), 7);
    chk("p8_valid", 32'(winner_valid8), 1);
    chk("p8_wins7", 32'(status8[255:252]), 1);
    chk("p8_wins0", 32'(status8[31:28]), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/match_ctrl.md
# match_ctrl

Parametrised N-player match controller for the tank game. It generalises the fixed two-tank, single-life, latch-forever `game_over` logic into a round/match state machine with per-player lives, respawn timers, round wins and a match winner. It sits between the per-player collision `hit` outputs and the tank/bullet units, driving their freeze and respawn inputs and the per-player status words read by the renderer.

## Interface

Parameters:

- `NUM_PLAYERS`, default 2: player count. Legal range 2..8.
- `LIVES`, default 3: lives per player per round. Legal range 1..15.
- `WINS_TO_MATCH`, default 3: round wins that end the match. Legal range 1..15.
- `RESPAWN_FRAMES`, default 60: frame ticks from a non-final hit to respawn. Legal range 1..63.
- `COUNTDOWN_FRAMES`, default 120: frame ticks of freeze before each round. Legal range 1..255.
- `ROUND_HOLD_FRAMES`, default 180: frame ticks of freeze after each round. Legal range 1..255.
- `PID_W`, default `$clog2(NUM_PLAYERS)`: width of player index.

Ports:

- `clk`, in, 1: the single clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `frame_tick`, in, 1: one-cycle pulse per video frame.
- `start`, in, 1: one-cycle pulse to begin a match.
- `hit`, in, `NUM_PLAYERS`: bit i is a one-cycle pulse meaning player i was hit.
- `freeze`, out, 1: high means tanks and bullets hold still. This replaces `game_over`.
- `respawn`, out, `NUM_PLAYERS`: one-cycle pulse per player meaning "reload spawn position".
- `alive`, out, `NUM_PLAYERS`: player is on the field.
- `eliminated`, out, `NUM_PLAYERS`: player's lives are exhausted for this round.
- `round_over`, out, 1: high in state ROUND_HOLD.
- `match_over`, out, 1: high in state MATCH_OVER.
- `winner`, out, `PID_W`: index of the last round or match winner.
- `winner_valid`, out, 1: `winner` is meaningful. Low after a draw.
- `status_data`, out, `32*NUM_PLAYERS`: word i is at `[32*i +: 32]`. Bit fields:
  - [31:28] wins
  - [27:24] lives
  - [23] alive
  - [22] eliminated
  - [21:16] respawn frames remaining
  - [15:3] zero
  - [2:0] state code

## Operation

State codes: IDLE=0, COUNTDOWN=1, PLAY=2, ROUND_HOLD=3, MATCH_OVER=4.

- **IDLE**
  - `freeze`=1.
  - `start` clears all wins, reloads lives, and goes to COUNTDOWN.
- **COUNTDOWN**
  - `freeze`=1.
  - On entry: counter is loaded with `COUNTDOWN_FRAMES`, every player's lives is set to `LIVES`, `alive`=0, `eliminated`=0, respawn timers are cleared.
  - Each `frame_tick` decrements the counter. The tick that takes it 1 to 0 moves to PLAY.
  - On that same edge `respawn` pulses all ones and `alive` is set to all ones.
- **PLAY**
  - `freeze`=0.
  - `hit[i]` is accepted only if `alive[i]`=1.
  - Accepted hit: `lives[i]` decrements and `alive[i]` clears.
    - If the new lives value is 0, `eliminated[i]` is set.
    - Otherwise respawn timer i is loaded with `RESPAWN_FRAMES`.
  - Each nonzero respawn timer decrements on `frame_tick`. The tick that takes it 1 to 0 sets `alive[i]` and pulses `respawn[i]` on the same edge.
  - Round ends when the count of non-eliminated players is 1 or fewer. The FSM evaluates the registered `eliminated` vector.
    - Exactly one survivor: that player's wins increment, `winner` is set to its index, `winner_valid`=1.
    - Zero survivors (a draw): no wins change, `winner_valid`=0.
  - When the round ends, go to ROUND_HOLD and load the hold counter with `ROUND_HOLD_FRAMES`. All respawn timers clear.
- **ROUND_HOLD**
  - `freeze`=1.
  - The counter decrements per `frame_tick`. At 0:
    - If any player's wins equal `WINS_TO_MATCH`, go to MATCH_OVER.
    - Otherwise go to COUNTDOWN.
- **MATCH_OVER**
  - `freeze`=1. `winner` and `winner_valid` hold.
  - `start` clears wins and goes to COUNTDOWN.
- `start` is ignored in COUNTDOWN, PLAY and ROUND_HOLD.
- `hit` is ignored outside PLAY.
- Simultaneous hits in one cycle are all applied on the same edge.
- Wins and lives are 4-bit registers, zero-extended into the status word.
- The respawn timer is 6 bits. Counters never go below 0.

## Timing

- **Reset** (asynchronous, `reset_n`=0) forces all state and outputs immediately, without waiting for a clock edge:
  - state IDLE, `freeze`=1, `respawn`=0, `alive`=0, `eliminated`=0
  - `round_over`=0, `match_over`=0, `winner`=0, `winner_valid`=0
  - all wins, lives and timers 0, so every `status_data` word is 0
- Reset release is synchronous to the next `clk` edge. Reset mid-round abandons the match with no winner update.
- **Hit latency.** A `hit` sampled at edge E updates `lives`, `alive`, `eliminated` and the timer at E. The status word reflects this after E.
- **Round-end latency.** The transition to ROUND_HOLD, with `freeze`=1 and the wins/`winner` update, occurs at E+1. Hits in the cycle between E and E+1 are still processed.
- **Respawn pulse.** `respawn` is exactly one cycle wide, asserted the cycle after the qualifying edge.
- **Frame ticks.** A `frame_tick` coinciding with a state entry is not counted toward the new state's counter.
- All outputs are registered.

## Test plan

1. **Reset and start.** Assert `reset_n`=0 mid-cycle: all outputs go to 0 with `freeze`=1 immediately. Release, pulse `start`, deliver 120 ticks: PLAY is entered, `respawn`=2'b11 for one cycle, `alive`=2'b11, `freeze`=0.
2. **Single hit and respawn.** `hit`=2'b01 in PLAY: `lives[0]`=2, `alive[0]`=0, `status_data[21:16]`=60. After 60 ticks: `respawn[0]` pulses and `alive[0]`=1. A repeat `hit[0]` while dead leaves lives at 2.
3. **Round win.** Hit player 1 three times, letting it respawn between hits: `eliminated[1]`=1, next edge `round_over`=1, `winner`=0, `winner_valid`=1, wins[0]=1. After 180 ticks: COUNTDOWN with lives reloaded to 3.
4. **Draw.** Both players have one life left and `hit`=2'b11 arrives in the same cycle: ROUND_HOLD is entered with `winner_valid`=0 and no wins change.
5. **Match end.** With `WINS_TO_MATCH`=3, player 1 wins three rounds: MATCH_OVER, `match_over`=1, `winner`=1. `start` clears wins and enters COUNTDOWN. `start` pulsed during PLAY is ignored.
6. **Eight players.** Set `NUM_PLAYERS`=8 and eliminate players 0 to 6: `winner`=7, `status_data[255:252]`=1.
